// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// the hardwired-zero register index and the load scoreboard entry.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        MEM_WAIT
    } hazard_state_t;

    localparam int unsigned REG_ZERO  = 0;
    localparam int unsigned RD_MAX_W  = 8;

    // Register indices are zero-extended to RD_MAX_W so the entry type is width-independent.
    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
    } sb_entry_t;

    function automatic logic src_match(input logic                use_src,
                                       input logic [RD_MAX_W-1:0] rs,
                                       input logic [RD_MAX_W-1:0] rd);
        return use_src && (rs != RD_MAX_W'(REG_ZERO)) && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Shift register of loads still in flight behind EX/MEM, and the
// source-operand match against every valid entry.
module load_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 3,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              load_valid,
    input  logic [REG_AW-1:0] load_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              use_rs1,
    input  logic              use_rs2,
    output logic              hit
);

    generate
        if (LOAD_LAT == 0) begin : g_none
            assign hit = 1'b0;
        end else begin : g_sb
            sb_entry_t sb_q [LOAD_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < LOAD_LAT; i++) sb_q[i] <= '0;
                end else if (advance) begin
                    sb_q[0] <= '{valid: load_valid, rd: RD_MAX_W'(load_rd)};
                    for (int unsigned i = 1; i < LOAD_LAT; i++) sb_q[i] <= sb_q[i-1];
                end
            end

            always_comb begin
                hit = 1'b0;
                for (int unsigned i = 0; i < LOAD_LAT; i++) begin
                    if (sb_q[i].valid &&
                        (src_match(use_rs1, RD_MAX_W'(rs1), sb_q[i].rd) ||
                         src_match(use_rs2, RD_MAX_W'(rs2), sb_q[i].rd)))
                        hit = 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, memory freeze, branch flush.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_ex_memread,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic [REG_AW-1:0] if_id_rs1,
    input  logic [REG_AW-1:0] if_id_rs2,
    input  logic              if_id_use_rs1,
    input  logic              if_id_use_rs2,
    input  logic              ex_branch_taken,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              ex_mem_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              stall_active
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
`endif
);

    hazard_state_t state_q, next_state;
    logic          sb_hit, lu_ex, lu;

    // Only a branch flush drops the EX load; a load-use bubble enters behind it.
    load_scoreboard #(.REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .advance    (mem_ready),
        .load_valid (id_ex_memread && !ex_branch_taken),
        .load_rd    (id_ex_rd),
        .rs1        (if_id_rs1),
        .rs2        (if_id_rs2),
        .use_rs1    (if_id_use_rs1),
        .use_rs2    (if_id_use_rs2),
        .hit        (sb_hit)
    );

    assign lu_ex = id_ex_memread &&
                   (src_match(if_id_use_rs1, RD_MAX_W'(if_id_rs1), RD_MAX_W'(id_ex_rd)) ||
                    src_match(if_id_use_rs2, RD_MAX_W'(if_id_rs2), RD_MAX_W'(id_ex_rd)));
    assign lu    = lu_ex || sb_hit;

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= next_state;
    end

    always_comb begin
        next_state = RUN;
        if (rst)                  next_state = RUN;
        else if (!mem_ready)      next_state = MEM_WAIT;
        else if (ex_branch_taken) next_state = RUN;
        else if (lu)              next_state = LU_STALL;
    end

    // Outputs follow this cycle's decision, never the registered state.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        stall_active = 1'b0;
        unique case (next_state)
            MEM_WAIT: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                ex_mem_write = 1'b0;
                stall_active = 1'b1;
            end
            LU_STALL: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_flush  = 1'b1;
                stall_active = 1'b1;
            end
            default: begin
                if_id_flush = !rst && ex_branch_taken;
                id_ex_flush = !rst && ex_branch_taken;
            end
        endcase
    end

    assert property (@(posedge clk) disable iff (rst)
        (CNT_W > 0) && (LOAD_LAT <= 4) && (state_q inside {RUN, LU_STALL, MEM_WAIT}));

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_active && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
            if (if_id_flush && flush_events != '1)  flush_events <= flush_events + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (LOAD_LAT=1): table-driven cycle vectors
// checked through an expected-value queue, plus counter checks with HAZARD_PERF_EN.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_ex_memread;
    logic [2:0] id_ex_rd, if_id_rs1, if_id_rs2;
    logic       if_id_use_rs1, if_id_use_rs2;
    logic       ex_branch_taken, mem_ready;
    logic       pc_write, if_id_write, ex_mem_write, if_id_flush, id_ex_flush, stall_active;
`ifdef HAZARD_PERF_EN
    logic [3:0] stall_cycles, flush_events;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(3), .LOAD_LAT(1), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_ex_memread   (id_ex_memread),
        .id_ex_rd        (id_ex_rd),
        .if_id_rs1       (if_id_rs1),
        .if_id_rs2       (if_id_rs2),
        .if_id_use_rs1   (if_id_use_rs1),
        .if_id_use_rs2   (if_id_use_rs2),
        .ex_branch_taken (ex_branch_taken),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .ex_mem_write    (ex_mem_write),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .stall_active    (stall_active)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
`endif
    );

    // expected output vector {pc_write, if_id_write, ex_mem_write, if_id_flush, id_ex_flush, stall_active}
    localparam logic [5:0] E_RUN = 6'b111000;
    localparam logic [5:0] E_LU  = 6'b001011;
    localparam logic [5:0] E_MEM = 6'b000001;
    localparam logic [5:0] E_BR  = 6'b111110;

    typedef struct {
        logic       rst, mr;
        logic [2:0] rd, rs1, rs2;
        logic       u1, u2, br, rdy;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;

    task automatic add(input logic r, input logic mr, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic u1, input logic [2:0] rs2,
                       input logic u2, input logic br, input logic rdy,
                       input logic [5:0] exp, input string name);
        vec_t v;
        v.rst = r; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.u1 = u1; v.u2 = u2; v.br = br; v.rdy = rdy; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [5:0] e;
        @(posedge clk);
        #1;
        rst = v.rst; id_ex_memread = v.mr; id_ex_rd = v.rd;
        if_id_rs1 = v.rs1; if_id_rs2 = v.rs2;
        if_id_use_rs1 = v.u1; if_id_use_rs2 = v.u2;
        ex_branch_taken = v.br; mem_ready = v.rdy;
        exp_q.push_back(v.exp);
        @(negedge clk);
        e = exp_q.pop_front();
        check_val(v.name, int'({pc_write, if_id_write, ex_mem_write,
                               if_id_flush, id_ex_flush, stall_active}), int'(e));
    endtask

    initial begin
        rst = 1'b1; id_ex_memread = 1'b0; id_ex_rd = '0; if_id_rs1 = '0; if_id_rs2 = '0;
        if_id_use_rs1 = 1'b0; if_id_use_rs2 = 1'b0; ex_branch_taken = 1'b0; mem_ready = 1'b1;

        //  rst mr rd rs1 u1 rs2 u2 br rdy  expected
        add(1, 1, 3, 3, 1, 0, 0, 0, 1, E_RUN, "reset_forces_run");
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN, "idle");
        add(0, 1, 3, 3, 1, 0, 0, 0, 1, E_LU,  "lu_x3_bubble1");
        add(0, 0, 0, 3, 1, 0, 0, 0, 1, E_LU,  "lu_x3_bubble2");
        add(0, 0, 0, 3, 1, 0, 0, 0, 1, E_RUN, "lu_x3_resume");
        add(0, 1, 0, 0, 1, 0, 1, 0, 1, E_RUN, "load_x0_no_stall");
        add(0, 0, 0, 0, 1, 0, 0, 0, 1, E_RUN, "load_x0_sb_no_stall");
        add(0, 1, 5, 1, 1, 5, 0, 0, 1, E_RUN, "unused_src_ex");
        add(0, 0, 0, 2, 1, 5, 0, 0, 1, E_RUN, "unused_src_sb");
        add(0, 1, 4, 1, 1, 0, 0, 0, 1, E_RUN, "gap1_load");
        add(0, 0, 1, 0, 0, 4, 1, 0, 1, E_LU,  "gap1_one_bubble");
        add(0, 0, 0, 0, 0, 4, 1, 0, 1, E_RUN, "gap1_resume");
        add(0, 1, 5, 5, 1, 0, 0, 0, 1, E_LU,  "mem_lu_first");
        add(0, 0, 0, 5, 1, 0, 0, 0, 0, E_MEM, "mem_wait1");
        add(0, 0, 0, 5, 1, 0, 0, 0, 0, E_MEM, "mem_wait2");
        add(0, 0, 0, 5, 1, 0, 0, 0, 0, E_MEM, "mem_wait3");
        add(0, 0, 0, 5, 1, 0, 0, 0, 1, E_LU,  "mem_lu_second");
        add(0, 0, 0, 5, 1, 0, 0, 0, 1, E_RUN, "mem_resume");
        add(0, 1, 6, 6, 1, 0, 0, 1, 1, E_BR,  "branch_beats_lu");
        add(0, 0, 0, 6, 1, 0, 0, 0, 1, E_RUN, "branch_no_later_stall");
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, E_MEM, "branch_held_mem");
        add(0, 0, 0, 0, 0, 0, 0, 1, 1, E_BR,  "branch_after_mem");
        add(0, 1, 2, 2, 1, 0, 0, 0, 1, E_LU,  "rst_mid_stall_pre");
        add(1, 0, 0, 2, 1, 0, 0, 0, 1, E_RUN, "rst_mid_stall_rst");
        add(0, 0, 0, 2, 1, 0, 0, 0, 1, E_RUN, "rst_sb_empty");

        foreach (vecs[i]) apply(vecs[i]);

`ifdef HAZARD_PERF_EN
        check_val("perf_stall_after_rst", int'(stall_cycles), 0);
        check_val("perf_flush_after_rst", int'(flush_events), 0);
        for (int i = 0; i < 20; i++)
            apply('{rst: 0, mr: 0, rd: 0, rs1: 0, rs2: 0, u1: 0, u2: 0, br: 0, rdy: 0,
                    exp: E_MEM, name: "perf_mem_stall"});
        for (int i = 0; i < 2; i++)
            apply('{rst: 0, mr: 0, rd: 0, rs1: 0, rs2: 0, u1: 0, u2: 0, br: 1, rdy: 1,
                    exp: E_BR, name: "perf_branch"});
        apply('{rst: 0, mr: 0, rd: 0, rs1: 0, rs2: 0, u1: 0, u2: 0, br: 0, rdy: 1,
                exp: E_RUN, name: "perf_idle"});
        check_val("perf_stall_saturated", int'(stall_cycles), 15);
        check_val("perf_flush_count", int'(flush_events), 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
